// File: rtl/modcnt_pkg.sv
// Shared constants and the step-decode enum for the modulo up/down counter.
package modcnt_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   typedef enum logic [2:0] {
      HOLD,
      LOAD,
      INC,
      DEC,
      WRAP_LO,
      WRAP_HI,
      PIN
   } step_op_e;

endpackage

// File: rtl/sat_event_counter.sv
// Generic saturating up-counter: steps on inc, sticks at all ones, cleared only by reset.
module sat_event_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (inc && (value_q != '1)) begin
         value_d = value_q + W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/modulo_counter_ud.sv
// Up/down modulo counter with programmable limit, load, wrap/saturate mode and registered tc.
// Optional wrap-event counter on wrap_count when MODCNT_WRAPCNT_EN is defined.
module modulo_counter_ud
   import modcnt_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0,
   parameter int WRAP_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             counter_en,
   input  logic             dir,
   input  logic [WIDTH-1:0] limit,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc
`ifdef MODCNT_WRAPCNT_EN
   ,
   output logic [WRAP_W-1:0] wrap_count
`endif
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tc_q;
   logic             tc_d;
   step_op_e         op;

   always_comb begin
      op   = HOLD;
      tc_d = 1'b0;
      if (load_en) begin
         op = LOAD;
      end else if (counter_en) begin
         if (dir == DIR_UP) begin
            if (count_q >= limit) begin
               op   = (SATURATE == MODE_SAT) ? PIN : WRAP_LO;
               tc_d = 1'b1;
            end else begin
               op = INC;
            end
         end else begin
            if (count_q == '0) begin
               op   = (SATURATE == MODE_SAT) ? PIN : WRAP_HI;
               tc_d = 1'b1;
            end else if (count_q > limit) begin
               // Limit shrank under us: clamp back into range, not a wrap event.
               op = WRAP_HI;
            end else begin
               op = DEC;
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      case (op)
         HOLD:    count_d = count_q;
         LOAD:    count_d = (load_value <= limit) ? load_value : limit;
         INC:     count_d = count_q + WIDTH'(1);
         DEC:     count_d = count_q - WIDTH'(1);
         WRAP_LO: count_d = '0;
         WRAP_HI: count_d = limit;
         PIN:     count_d = (dir == DIR_UP) ? limit : '0;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;

`ifdef MODCNT_WRAPCNT_EN
   sat_event_counter #(
      .W(WRAP_W)
   ) u_wrap_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (tc_d),
      .value (wrap_count)
   );
`endif

endmodule

// File: tb/tb_modulo_counter_ud.sv
// Directed self-checking bench for modulo_counter_ud (wrap, saturate and cascaded instances).
module tb_modulo_counter_ud;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       counter_en = 1'b0;
   logic       dir = 1'b1;
   logic       load_en = 1'b0;
   logic [3:0] limit = 4'd9;
   logic [3:0] load_value = 4'd0;

   logic [3:0] c0, c1, c2;
   logic       t0, t1, t2;
`ifdef MODCNT_WRAPCNT_EN
   logic [1:0] w0;
   logic [7:0] w1;
   logic [7:0] w2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   // Wrap-mode instance, also stage A of the cascade; narrow wrap counter to reach saturation.
   modulo_counter_ud #(.WIDTH(4), .SATURATE(0), .WRAP_W(2)) u_wrap (
      .clock      (clock),
      .reset      (reset),
      .counter_en (counter_en),
      .dir        (dir),
      .limit      (limit),
      .load_en    (load_en),
      .load_value (load_value),
      .count      (c0),
      .tc         (t0)
`ifdef MODCNT_WRAPCNT_EN
      ,
      .wrap_count (w0)
`endif
   );

   modulo_counter_ud #(.WIDTH(4), .SATURATE(1), .WRAP_W(8)) u_sat (
      .clock      (clock),
      .reset      (reset),
      .counter_en (counter_en),
      .dir        (dir),
      .limit      (limit),
      .load_en    (load_en),
      .load_value (load_value),
      .count      (c1),
      .tc         (t1)
`ifdef MODCNT_WRAPCNT_EN
      ,
      .wrap_count (w1)
`endif
   );

   // Stage B of the cascade, enabled by stage A's tc.
   modulo_counter_ud #(.WIDTH(4), .SATURATE(0), .WRAP_W(8)) u_stage_b (
      .clock      (clock),
      .reset      (reset),
      .counter_en (t0),
      .dir        (1'b1),
      .limit      (limit),
      .load_en    (1'b0),
      .load_value (4'd0),
      .count      (c2),
      .tc         (t2)
`ifdef MODCNT_WRAPCNT_EN
      ,
      .wrap_count (w2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Power-on reset
      tick();
      tick();
      check("rst_count", 32'(c0), 32'd0);
      check("rst_tc", 32'(t0), 32'd0);
`ifdef MODCNT_WRAPCNT_EN
      check("rst_wrap", 32'(w0), 32'd0);
`endif
      reset = 1'b0;

      // Up wrap with limit 9
      counter_en = 1'b1;
      dir = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         check("up_count", 32'(c0), 32'(i % 10));
         check("up_tc", 32'(t0), (i == 10) ? 32'd1 : 32'd0);
`ifdef MODCNT_WRAPCNT_EN
         check("up_wrap", 32'(w0), (i >= 10) ? 32'd1 : 32'd0);
`endif
      end

      // Down wrap from 2: 1, 0, 9 (tc), 8
      dir = 1'b0;
      tick(); check("dn_count1", 32'(c0), 32'd1); check("dn_tc1", 32'(t0), 32'd0);
      tick(); check("dn_count0", 32'(c0), 32'd0); check("dn_tc0", 32'(t0), 32'd0);
      tick(); check("dn_count9", 32'(c0), 32'd9); check("dn_tc9", 32'(t0), 32'd1);
`ifdef MODCNT_WRAPCNT_EN
      check("dn_wrap", 32'(w0), 32'd2);
`endif
      tick(); check("dn_count8", 32'(c0), 32'd8); check("dn_tc8", 32'(t0), 32'd0);

      // Limit shrinks below count, step up
      limit = 4'd5;
      dir = 1'b1;
      tick(); check("shrink_up_count", 32'(c0), 32'd0); check("shrink_up_tc", 32'(t0), 32'd1);
`ifdef MODCNT_WRAPCNT_EN
      check("shrink_wrap", 32'(w0), 32'd3);
`endif

      // Load 8 under limit 15, then step down under limit 5
      limit = 4'd15;
      load_en = 1'b1;
      load_value = 4'd8;
      counter_en = 1'b0;
      tick(); check("load8_count", 32'(c0), 32'd8); check("load8_tc", 32'(t0), 32'd0);
      load_en = 1'b0;
      limit = 4'd5;
      dir = 1'b0;
      counter_en = 1'b1;
      tick(); check("shrink_dn_count", 32'(c0), 32'd5); check("shrink_dn_tc", 32'(t0), 32'd0);

      // Hold
      counter_en = 1'b0;
      tick(); check("hold_count", 32'(c0), 32'd5); check("hold_tc", 32'(t0), 32'd0);

      // Load beats step; load clamps to limit
      limit = 4'd9;
      load_en = 1'b1;
      load_value = 4'd3;
      counter_en = 1'b1;
      dir = 1'b1;
      tick(); check("ldprio_count", 32'(c0), 32'd3); check("ldprio_tc", 32'(t0), 32'd0);
      load_value = 4'd12;
      tick(); check("ldclamp_count", 32'(c0), 32'd9); check("ldclamp_tc", 32'(t0), 32'd0);
      load_en = 1'b0;

      // limit 0: stays 0 and every step pulses tc; 2-bit wrap counter saturates at 3
      limit = 4'd0;
      tick(); check("lim0_a_count", 32'(c0), 32'd0); check("lim0_a_tc", 32'(t0), 32'd1);
      tick(); check("lim0_b_count", 32'(c0), 32'd0); check("lim0_b_tc", 32'(t0), 32'd1);
      dir = 1'b0;
      tick(); check("lim0_c_count", 32'(c0), 32'd0); check("lim0_c_tc", 32'(t0), 32'd1);
`ifdef MODCNT_WRAPCNT_EN
      check("wrap_sat", 32'(w0), 32'd3);
`endif

      // Asynchronous reset mid-count at 7, between edges
      limit = 4'd9;
      dir = 1'b1;
      load_en = 1'b1;
      load_value = 4'd7;
      tick(); check("pre_rst_count", 32'(c0), 32'd7);
      load_en = 1'b0;
      counter_en = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_count", 32'(c0), 32'd0);
      check("async_rst_tc", 32'(t0), 32'd0);
`ifdef MODCNT_WRAPCNT_EN
      check("async_rst_wrap", 32'(w0), 32'd0);
`endif
      #2;
      reset = 1'b0;

      // Saturate mode, limit 9
      for (int i = 1; i <= 12; i++) begin
         tick();
         check("sat_up_count", 32'(c1), (i < 9) ? 32'(i) : 32'd9);
         check("sat_up_tc", 32'(t1), (i >= 10) ? 32'd1 : 32'd0);
      end
      dir = 1'b0;
      tick(); check("sat_flip_count", 32'(c1), 32'd8); check("sat_flip_tc", 32'(t1), 32'd0);
      for (int v = 7; v >= 0; v--) begin
         tick();
         check("sat_dn_count", 32'(c1), 32'(v));
         check("sat_dn_tc", 32'(t1), 32'd0);
      end
      tick(); check("sat_pin0_count", 32'(c1), 32'd0); check("sat_pin0_tc", 32'(t1), 32'd1);
      tick(); check("sat_pin0b_count", 32'(c1), 32'd0); check("sat_pin0b_tc", 32'(t1), 32'd1);
`ifdef MODCNT_WRAPCNT_EN
      check("sat_wrap", 32'(w1), 32'd5);
`endif

      // Cascade: stage B steps one cycle after each stage A wrap
      reset = 1'b1;
      dir = 1'b1;
      #2;
      reset = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         check("casc_a_count", 32'(c0), 32'(i % 10));
         check("casc_a_tc", 32'(t0), ((i % 10) == 0) ? 32'd1 : 32'd0);
         check("casc_b_count", 32'(c2), 32'(((i - 1) / 10) % 10));
         check("casc_b_tc", 32'(t2), 32'd0);
      end
      tick();
      check("casc_b_wrap_count", 32'(c2), 32'd0);
      check("casc_b_wrap_tc", 32'(t2), 32'd1);
`ifdef MODCNT_WRAPCNT_EN
      check("casc_b_wrapcnt", 32'(w2), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/modulo_counter_ud.md
# modulo_counter_ud

Parametrised modulo counter with up/down direction, runtime-programmable terminal value, synchronous load and a registered terminal-count pulse. It generalises the 4-bit enable-gated modulo counter to any width, adds a saturate mode, and can be cascaded through `tc` to build multi-digit timers and dividers. It sits in timer and prescaler paths and drives display digits.

## Interface
- `WIDTH`, default 4: count register width in bits.
- `SATURATE`, default 0: 0 means wrap at the boundary; 1 means hold at the boundary.
- `WRAP_W`, default 8: width of the wrap-event counter; only used with `MODCNT_WRAPCNT_EN`.
- `clock`, input, 1: single clock domain, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `counter_en`, input, 1: step enable. At 0 the count holds.
- `dir`, input, 1: step direction. 1 counts up, 0 counts down.
- `limit`, input, WIDTH: terminal value. The count range is 0..`limit` inclusive. It is sampled every cycle.
- `load_en`, input, 1: synchronous load strobe.
- `load_value`, input, WIDTH: value to load.
- `count`, output, WIDTH: registered count.
- `tc`, output, 1: registered terminal-count flag.
- `wrap_count`, output, WRAP_W: registered count of wrap events. Present only with `MODCNT_WRAPCNT_EN`.

## Operation
- Priority order is `reset`, then `load_en`, then `counter_en`, then hold.
- Load: `count` <= `load_value` when `load_value` <= `limit`, otherwise `limit`. Load never asserts `tc`.
- Up step, wrap mode:
  - `count` == `limit` gives 0 with `tc`=1.
  - `count` > `limit` (after a runtime decrease of `limit`) gives 0 with `tc`=1.
  - Otherwise `count`+1.
- Down step, wrap mode:
  - `count` == 0 gives `limit` with `tc`=1.
  - `count` > `limit` gives `limit` with `tc`=0.
  - Otherwise `count`-1.
- Saturate mode:
  - An up step at `count` >= `limit` gives `limit`.
  - A down step at 0 gives 0.
  - `tc`=1 whenever the step was attempted at the boundary, i.e. the count is pinned.
- `limit`=0: the count stays 0. In wrap mode, every enabled step pulses `tc`.
- `tc` is 0 in every cycle not listed above, including hold cycles.
- Arithmetic is unsigned and modulo 2^WIDTH internally. No out-of-range value is ever visible on `count`.
- `dir` may change on any cycle. The step uses the `dir` sampled at that edge.

## Timing
- Reset values: `count`=0, `tc`=0, `wrap_count`=0. Reset asserted mid-count clears all of them immediately, without waiting for a clock edge.
- Latency is 1 cycle from a sampled input to `count`/`tc`.
- `tc` is high in the same cycle that `count` first shows the wrapped or pinned value. It is one cycle wide per event in wrap mode.
- Cascading: the next stage's `counter_en` is driven from this stage's `tc`. That stage then steps one cycle after the wrap, which is a fixed, documented skew of 1 cycle per stage.
- Load and step on the same edge: the load wins and no step occurs.
- There is no combinational path from inputs to outputs.

## Configuration
- `MODCNT_WRAPCNT_EN` defined:
  - A `WRAP_W`-bit counter increments on every cycle in which `tc` is asserted by a step.
  - It saturates at all ones and does not wrap.
  - It is cleared only by `reset`.
  - It is exposed on `wrap_count`.
- Not defined: the `wrap_count` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `modcnt_pkg` holds:
  - `DIR_UP`=1 and `DIR_DOWN`=0.
  - `MODE_WRAP`=0 and `MODE_SAT`=1.
  - A next-state decode enum: HOLD, LOAD, INC, DEC, WRAP_LO, WRAP_HI, PIN.
- Main block: one registered next-state process plus one combinational decode of the above enum.
- Sub-module `sat_event_counter`, instantiated only under `MODCNT_WRAPCNT_EN`:
  - Generic saturating up-counter, parameter `W`.
  - Ports: `clock`, `reset`, `inc`, `value`.

## Test plan
All scenarios use WIDTH=4 unless stated.

- **Reset:** assert `reset` asynchronously mid-count at 7, between edges. `count`=0, `tc`=0 and `wrap_count`=0 with no clock edge.
- **Up wrap:** `limit`=9, `dir`=1, enable held for 12 cycles from 0. Sequence 0..9,0,1,2. `tc`=1 only in the cycle `count` shows 0 after 9. With `MODCNT_WRAPCNT_EN`, `wrap_count` goes to 1 in that cycle.
- **Down wrap and limit shrink:**
  - From 2 with `dir`=0: sequence 2,1,0,9 with `tc` on 9.
  - Then at `count`=8 set `limit`=5 and step up: gives 0 with `tc`=1.
  - Then set `count`=8 via `limit`=15 and a load, restore `limit`=5 and step down: gives 5 with `tc`=0.
- **Load priority:**
  - `load_en`=1 with `load_value`=3 and `counter_en`=1 in the same cycle: `count`=3, no step, `tc`=0.
  - `load_value`=12 with `limit`=9: `count`=9.
- **Saturate:** SATURATE=1, `limit`=9. Counting up pins at 9 with `tc`=1 each enabled cycle. Counting down pins at 0 with `tc`=1. `dir` flip from 9 gives 8 with `tc`=0.
- **Cascade:** two instances, with stage B `counter_en` driven by stage A `tc`, both `limit`=9, 100 enables. B counts 0..9 and A wraps ten times. B steps one cycle after each A wrap.
